stage1_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the stage-2 decode/immediate-generation logic.
- Holds the PC, issues in-order word requests to instruction memory, and buffers returned words with their PCs in a small FIFO.
- Presents one {instruction, pc} pair per cycle to stage 2 over a valid/ready handshake.
- Handles control-flow redirects from later stages by flushing the FIFO and discarding in-flight responses.

---
 rtl/stage1_fetch.sv | 235 +++++++++++++++++++++++
 tb/tb_stage1_fetch.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage1_fetch.sv
// stage1_fetch
// Instruction-fetch stage feeding the stage-2 decode/immediate logic.
// Keeps the fetch PC, issues in-order word requests to instruction memory,
// buffers returned words together with their PCs and hands one
// {instruction, pc} pair per cycle to stage 2 over valid/ready.
// Redirects from later stages flush the buffer and discard every response
// that is still in flight.
//
// Ports:
//   clk, rst          clock (rising edge) and async active-high reset
//   imem_req_*        request channel: valid/ready plus word address (PC)
//   imem_rsp_*        response channel: in order, one per accepted request,
//                     never backpressured
//   id_valid/id_ready handshake towards stage 2
//   id_instr, id_pc   instruction word and its PC (buffer head)
//   id_misaligned     (optional) head entry marks a misaligned redirect
//   redirect_valid/pc one-cycle control-flow redirect
//
// Optional feature macro: STAGE1_FETCH_MISALIGN_CHK_EN
//   Defined:   adds id_misaligned; a redirect to a non-word-aligned target
//              flushes, enqueues one NOP entry carrying the raw target PC and
//              halts fetch until the next redirect.
//   Undefined: the low two bits of redirect_pc are simply ignored.
module stage1_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
`ifdef STAGE1_FETCH_MISALIGN_CHK_EN
  output logic        id_misaligned,
`endif
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] fifoCount_q, fifoCount_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] tagWrPtr_q, tagWrPtr_d;
  logic [PTR_W-1:0] tagRdPtr_q, tagRdPtr_d;

  logic [31:0] instrBuf_q [FIFO_DEPTH];
  logic [31:0] pcBuf_q    [FIFO_DEPTH];
  logic [31:0] tagPc_q    [FIFO_DEPTH];

  logic        fifoEmpty;
  logic        fifoFull;
  logic        creditOk;
  logic        fetchHalt;
  logic        reqFire;
  logic        pushEn;
  logic        popEn;
  logic        redirMis;
  logic [31:0] redirTarget;

`ifdef STAGE1_FETCH_MISALIGN_CHK_EN
  logic halt_q, halt_d;
  logic misBuf_q [FIFO_DEPTH];

  assign fetchHalt     = halt_q;
  assign redirMis      = (redirect_pc[1:0] != 2'b00);
  assign id_misaligned = misBuf_q[rdPtr_q];
`else
  assign fetchHalt = 1'b0;
  assign redirMis  = 1'b0;
`endif

  // Redirect targets are always fetched from a word boundary.
  assign redirTarget = redirect_pc & 32'hFFFF_FFFC;

  assign fifoEmpty = (fifoCount_q == '0);
  assign fifoFull  = (fifoCount_q == DEPTH_CNT);

  // Credit: every in-flight request (kept or to-be-dropped) reserves a slot,
  // so a kept response can never find the buffer full.
  assign creditOk = ({1'b0, outstanding_q} + {1'b0, fifoCount_q}) < DEPTH_EXT;

  // Request side: gated while in reset so nothing leaves before release.
  assign imem_req_valid = !rst && !redirect_valid && !fetchHalt && creditOk;
  assign imem_req_addr  = pc_q;
  assign reqFire        = imem_req_valid && imem_req_ready;

  // A response in a redirect cycle is discarded along with the drop backlog.
  assign pushEn = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

  // Output side: head of the buffer, suppressed during a redirect cycle.
  assign id_valid = !fifoEmpty && !redirect_valid;
  assign id_instr = instrBuf_q[rdPtr_q];
  assign id_pc    = pcBuf_q[rdPtr_q];
  assign popEn    = id_valid && id_ready;

  // Next-state logic for the PC, the in-flight counters and all pointers.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    fifoCount_d   = fifoCount_q;
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    tagWrPtr_d    = tagWrPtr_q;
    tagRdPtr_d    = tagRdPtr_q;
`ifdef STAGE1_FETCH_MISALIGN_CHK_EN
    halt_d        = halt_q;
`endif

    if (reqFire) begin
      pc_d       = pc_q + 32'd4;
      tagWrPtr_d = tagWrPtr_q + 1'b1;
    end
    if (imem_rsp_valid) begin
      tagRdPtr_d = tagRdPtr_q + 1'b1;
    end

    outstanding_d = outstanding_q + {{(CNT_W-1){1'b0}}, reqFire}
                                  - {{(CNT_W-1){1'b0}}, imem_rsp_valid};

    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old
      // path; that already includes any earlier drop backlog, so repeated
      // redirects accumulate without double counting.
      pc_d        = redirTarget;
      drop_d      = outstanding_q - {{(CNT_W-1){1'b0}}, imem_rsp_valid};
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      fifoCount_d = '0;
      if (redirMis) begin
        wrPtr_d     = PTR_W'(1);
        fifoCount_d = CNT_W'(1);
      end
`ifdef STAGE1_FETCH_MISALIGN_CHK_EN
      halt_d = redirMis;
`endif
    end else begin
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
      if (pushEn) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (popEn) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      fifoCount_d = fifoCount_q + {{(CNT_W-1){1'b0}}, pushEn}
                                - {{(CNT_W-1){1'b0}}, popEn};
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      fifoCount_q   <= '0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      tagWrPtr_q    <= '0;
      tagRdPtr_q    <= '0;
`ifdef STAGE1_FETCH_MISALIGN_CHK_EN
      halt_q        <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fifoCount_q   <= fifoCount_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      tagWrPtr_q    <= tagWrPtr_d;
      tagRdPtr_q    <= tagRdPtr_d;
`ifdef STAGE1_FETCH_MISALIGN_CHK_EN
      halt_q        <= halt_d;
`endif
    end
  end

  // Buffer and PC-tag storage. The PC of a response is the tag recorded
  // when its request was accepted, read in request order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instrBuf_q[i] <= '0;
        pcBuf_q[i]    <= '0;
        tagPc_q[i]    <= '0;
`ifdef STAGE1_FETCH_MISALIGN_CHK_EN
        misBuf_q[i]   <= 1'b0;
`endif
      end
    end else begin
      if (reqFire) begin
        tagPc_q[tagWrPtr_q] <= pc_q;
      end
      if (pushEn) begin
        instrBuf_q[wrPtr_q] <= imem_rsp_data;
        pcBuf_q[wrPtr_q]    <= tagPc_q[tagRdPtr_q];
`ifdef STAGE1_FETCH_MISALIGN_CHK_EN
        misBuf_q[wrPtr_q]   <= 1'b0;
`endif
      end
`ifdef STAGE1_FETCH_MISALIGN_CHK_EN
      // A misaligned redirect leaves exactly one marker entry in slot 0.
      if (redirect_valid && redirMis) begin
        instrBuf_q[0] <= NOP_INSTR;
        pcBuf_q[0]    <= redirect_pc;
        misBuf_q[0]   <= 1'b1;
      end
`endif
    end
  end

  // The credit scheme must make these impossible.
  assert property (@(posedge clk) disable iff (rst) !(pushEn && fifoFull));
  assert property (@(posedge clk) disable iff (rst) outstanding_q <= DEPTH_CNT);
  assert property (@(posedge clk) disable iff (rst) fifoCount_q <= DEPTH_CNT);

endmodule

// File: tb/tb_stage1_fetch.sv
// Directed testbench for stage1_fetch. A main instance with RESET_PC=0 runs
// against a variable-latency in-order memory model; a second instance with
// RESET_PC=0xFFFF_FFF8 checks PC wrap-around.
module tb_stage1_fetch;

  localparam logic [31:0] XOR_PAT = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqReady, rspValid;
  logic [31:0] reqAddr, rspData;
  logic        idValid, idReady;
  logic [31:0] idInstr, idPc;
  logic        redirValid;
  logic [31:0] redirPc;
`ifdef STAGE1_FETCH_MISALIGN_CHK_EN
  logic        idMis;
  logic        wIdMis;
`endif

  logic        wReqValid, wRspValid, wIdValid;
  logic [31:0] wReqAddr, wRspData, wIdInstr, wIdPc;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  stage1_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (reqValid),
    .imem_req_ready (reqReady),
    .imem_req_addr  (reqAddr),
    .imem_rsp_valid (rspValid),
    .imem_rsp_data  (rspData),
    .id_valid       (idValid),
`ifdef STAGE1_FETCH_MISALIGN_CHK_EN
    .id_misaligned  (idMis),
`endif
    .id_ready       (idReady),
    .id_instr       (idInstr),
    .id_pc          (idPc),
    .redirect_valid (redirValid),
    .redirect_pc    (redirPc)
  );

  stage1_fetch #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (wReqValid),
    .imem_req_ready (1'b1),
    .imem_req_addr  (wReqAddr),
    .imem_rsp_valid (wRspValid),
    .imem_rsp_data  (wRspData),
    .id_valid       (wIdValid),
`ifdef STAGE1_FETCH_MISALIGN_CHK_EN
    .id_misaligned  (wIdMis),
`endif
    .id_ready       (1'b1),
    .id_instr       (wIdInstr),
    .id_pc          (wIdPc),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0)
  );

  // Free-running cycle counter used to timestamp requests and pops.
  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Memory model for the main instance: each accepted request returns
  // addr ^ XOR_PAT exactly memLatency cycles later, in order.
  int          memLatency;
  logic [31:0] memAddrQ[$];
  int          memDueQ[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      memAddrQ.delete();
      memDueQ.delete();
      rspValid <= 1'b0;
      rspData  <= '0;
    end else begin
      if (reqValid && reqReady) begin
        memAddrQ.push_back(reqAddr);
        memDueQ.push_back(cycleCnt + memLatency);
      end
      if (memDueQ.size() > 0 && memDueQ[0] == cycleCnt + 1) begin
        rspValid <= 1'b1;
        rspData  <= memAddrQ[0] ^ XOR_PAT;
        void'(memAddrQ.pop_front());
        void'(memDueQ.pop_front());
      end else begin
        rspValid <= 1'b0;
      end
    end
  end

  // The wrap instance always sees a one-cycle memory.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wRspValid <= 1'b0;
      wRspData  <= '0;
    end else begin
      wRspValid <= wReqValid;
      wRspData  <= wReqAddr ^ XOR_PAT;
    end
  end

  // Monitors: record every accepted request and every stage-2 pop.
  int          reqCount;
  int          firstReqCycle;
  logic [31:0] popPcQ[$];
  logic [31:0] popInstrQ[$];
  int          popCycleQ[$];
  logic        popMisQ[$];
  logic [31:0] wPopPcQ[$];
  logic [31:0] wPopInstrQ[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      reqCount      <= 0;
      firstReqCycle <= -1;
      popPcQ.delete();
      popInstrQ.delete();
      popCycleQ.delete();
      popMisQ.delete();
      wPopPcQ.delete();
      wPopInstrQ.delete();
    end else begin
      if (reqValid && reqReady) begin
        reqCount <= reqCount + 1;
        if (reqCount == 0) firstReqCycle <= cycleCnt;
      end
      if (idValid && idReady) begin
        popPcQ.push_back(idPc);
        popInstrQ.push_back(idInstr);
        popCycleQ.push_back(cycleCnt);
`ifdef STAGE1_FETCH_MISALIGN_CHK_EN
        popMisQ.push_back(idMis);
`else
        popMisQ.push_back(1'b0);
`endif
      end
      if (wIdValid) begin
        wPopPcQ.push_back(wIdPc);
        wPopInstrQ.push_back(wIdInstr);
      end
    end
  end

  function automatic logic [31:0] pcAt(int i);
    return (i < popPcQ.size()) ? popPcQ[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] instrAt(int i);
    return (i < popInstrQ.size()) ? popInstrQ[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic int cycleAt(int i);
    return (i < popCycleQ.size()) ? popCycleQ[i] : -1000;
  endfunction
  function automatic logic [31:0] misAt(int i);
    return (i < popMisQ.size()) ? 32'(popMisQ[i]) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] wPcAt(int i);
    return (i < wPopPcQ.size()) ? wPopPcQ[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] wInstrAt(int i);
    return (i < wPopInstrQ.size()) ? wPopInstrQ[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive all inputs just after a falling edge, then let them settle.
  task automatic applyStimulus(input logic rr, input logic ir, input logic rv,
                               input logic [31:0] rp);
    @(negedge clk);
    reqReady   = rr;
    idReady    = ir;
    redirValid = rv;
    redirPc    = rp;
    #1;
  endtask

  task automatic holdReset(input logic rr, input logic ir, input int lat);
    @(negedge clk);
    rst        = 1'b1;
    reqReady   = rr;
    idReady    = ir;
    redirValid = 1'b0;
    redirPc    = '0;
    memLatency = lat;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitReqs(input int n, input int budget);
    int guard = 0;
    while (reqCount < n && guard < budget) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("requests issued", 32'(reqCount), 32'(n));
  endtask

  // Bounded overall run time; the directed sequence finishes long before.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int rb;
    rst        = 1'b1;
    reqReady   = 1'b0;
    idReady    = 1'b0;
    redirValid = 1'b0;
    redirPc    = '0;
    memLatency = 1;

    // Reset state.
    holdReset(1'b1, 1'b1, 1);
    checkOutput("reset req_valid", 32'(reqValid), 32'd0);
    checkOutput("reset id_valid", 32'(idValid), 32'd0);
    checkOutput("reset id_instr", idInstr, 32'h0);
    checkOutput("reset id_pc", idPc, 32'h0);
    checkOutput("reset req_addr", reqAddr, 32'h0);
    checkOutput("reset wrap req_addr", wReqAddr, 32'hFFFF_FFF8);
`ifdef STAGE1_FETCH_MISALIGN_CHK_EN
    checkOutput("reset id_misaligned", 32'(idMis), 32'd0);
`endif

    // Streaming with 1-cycle memory: one entry per cycle, wrap instance too.
    releaseReset();
    repeat (12) @(negedge clk);
    checkOutput("t1 first pop latency", 32'(cycleAt(0) - firstReqCycle), 32'd2);
    for (int k = 0; k < 8; k++) begin
      checkOutput("t1 pc", pcAt(k), 32'(4 * k));
      checkOutput("t1 instr", instrAt(k), 32'(4 * k) ^ XOR_PAT);
      checkOutput("t1 pop cycle", 32'(cycleAt(k) - cycleAt(0)), 32'(k));
    end
    checkOutput("t5 wrap pc0", wPcAt(0), 32'hFFFF_FFF8);
    checkOutput("t5 wrap pc1", wPcAt(1), 32'hFFFF_FFFC);
    checkOutput("t5 wrap pc2", wPcAt(2), 32'h0000_0000);
    checkOutput("t5 wrap instr2", wInstrAt(2), XOR_PAT);

    // Backpressure: buffer fills to depth, fetch stops, head stays put.
    holdReset(1'b1, 1'b0, 1);
    releaseReset();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t2 early head pc", idPc, 32'h0);
    repeat (7) @(negedge clk);
    #1;
    checkOutput("t2 req count", 32'(reqCount), 32'd4);
    checkOutput("t2 req_valid low", 32'(reqValid), 32'd0);
    checkOutput("t2 id_valid", 32'(idValid), 32'd1);
    checkOutput("t2 held head pc", idPc, 32'h0);
    checkOutput("t2 held head instr", idInstr, XOR_PAT);
    checkOutput("t2 no pops", 32'(popPcQ.size()), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      checkOutput("t2 drain pc", pcAt(k), 32'(4 * k));
    end

    // 3-cycle memory, redirect with three requests in flight.
    holdReset(1'b1, 1'b1, 3);
    releaseReset();
    waitReqs(3, 20);
    redirValid = 1'b1;
    redirPc    = 32'h0000_0100;
    #1;
    checkOutput("t3 req_valid in redirect", 32'(reqValid), 32'd0);
    checkOutput("t3 id_valid in redirect", 32'(idValid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t3 req_addr after redirect", reqAddr, 32'h0000_0100);
    checkOutput("t3 req count after redirect", 32'(reqCount), 32'd3);
    repeat (12) @(negedge clk);
    checkOutput("t3 first pc", pcAt(0), 32'h0000_0100);
    checkOutput("t3 first instr", instrAt(0), 32'h0000_0100 ^ XOR_PAT);
    checkOutput("t3 second pc", pcAt(1), 32'h0000_0104);

    // Back-to-back redirects while responses are still being dropped.
    holdReset(1'b1, 1'b1, 3);
    releaseReset();
    waitReqs(3, 20);
    redirValid = 1'b1;
    redirPc    = 32'h0000_0100;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0180);
    checkOutput("t3b req_valid in 2nd redirect", 32'(reqValid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t3b req_addr", reqAddr, 32'h0000_0180);
    checkOutput("t3b req count", 32'(reqCount), 32'd3);
    repeat (12) @(negedge clk);
    checkOutput("t3b first pc", pcAt(0), 32'h0000_0180);
    checkOutput("t3b second pc", pcAt(1), 32'h0000_0184);

    // Redirect coinciding with a response and a would-be pop.
    holdReset(1'b1, 1'b1, 1);
    releaseReset();
    repeat (6) @(negedge clk);
    idx = popPcQ.size();
    checkOutput("t4 pops before redirect", 32'(idx), 32'd4);
    redirValid = 1'b1;
    redirPc    = 32'h0000_0200;
    #1;
    checkOutput("t4 id_valid in redirect", 32'(idValid), 32'd0);
    checkOutput("t4 req_valid in redirect", 32'(reqValid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (8) @(negedge clk);
    checkOutput("t4 pc after redirect", pcAt(idx), 32'h0000_0200);
    checkOutput("t4 instr after redirect", instrAt(idx), 32'h0000_0200 ^ XOR_PAT);
    checkOutput("t4 next pc", pcAt(idx + 1), 32'h0000_0204);

`ifndef STAGE1_FETCH_MISALIGN_CHK_EN
    // Low target bits are ignored in the default build.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0303);
    idx = popPcQ.size();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (8) @(negedge clk);
    checkOutput("t6 aligned pc", pcAt(idx), 32'h0000_0300);
    checkOutput("t6 aligned next pc", pcAt(idx + 1), 32'h0000_0304);
`else
    // Misaligned redirect: one marker entry, then fetch halts.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0102);
    idx = popPcQ.size();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    rb = reqCount;
    checkOutput("t6 req_valid halted", 32'(reqValid), 32'd0);
    repeat (8) @(negedge clk);
    checkOutput("t6 mis pc", pcAt(idx), 32'h0000_0102);
    checkOutput("t6 mis instr", instrAt(idx), 32'h0000_0013);
    checkOutput("t6 mis flag", misAt(idx), 32'd1);
    checkOutput("t6 single entry", 32'(popPcQ.size()), 32'(idx + 1));
    checkOutput("t6 no requests while halted", 32'(reqCount), 32'(rb));
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (8) @(negedge clk);
    checkOutput("t6 resume pc", pcAt(idx + 1), 32'h0000_0040);
    checkOutput("t6 resume mis flag", misAt(idx + 1), 32'd0);
    checkOutput("t6 resume instr", instrAt(idx + 1), 32'h0000_0040 ^ XOR_PAT);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
